// File: rtl/tpu_package.sv
// tpu_package
//   Shared types and constants for the weight-load path of the systolic array.
//   MUL_SIZE            : array dimension, rows per weight tile (power of two)
//   TILE_SHIFT          : log2(MUL_SIZE); converts a tile index to a row offset
//   weight_load_state_t : weight-load FSM state encoding
package tpu_package;

  localparam int MUL_SIZE   = 32;
  localparam int TILE_SHIFT = $clog2(MUL_SIZE);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    FETCH     = 2'd1,
    WAIT_SWAP = 2'd2,
    DRAIN     = 2'd3
  } weight_load_state_t;

endpackage

// File: rtl/weight_tile_addr_gen.sv
// weight_tile_addr_gen
//   Tracks which weight tile is being fetched (ty inner, tx outer) and forms
//   the weight memory row address: base + tile_idx*MUL_SIZE + row, mod 2^ADDR_W.
// Ports
//   clk_i, rst_i  : clock, asynchronous active-low reset
//   start         : latch dims/base and restart at tile 0
//   advance       : step to the next tile (ty inner, tx outer)
//   h_dim, w_dim  : H/W dimension minus 1
//   base_addr     : address of row 0 of tile 0
//   row           : row within the current tile
//   addr          : weight memory address of that row
//   last_tile     : current tile is the final tile of the job
module weight_tile_addr_gen
  import tpu_package::*;
#(
  parameter int MUL_SIZE = 32,
  parameter int ADDR_W   = 12,
  parameter int DIM_W    = 9,
  localparam int ROW_W   = $clog2(MUL_SIZE)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start,
  input  logic              advance,
  input  logic [DIM_W-1:0]  h_dim,
  input  logic [DIM_W-1:0]  w_dim,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ROW_W-1:0]  row,
  output logic [ADDR_W-1:0] addr,
  output logic              last_tile
);

  localparam int TS    = $clog2(MUL_SIZE);
  localparam int CNT_W = DIM_W - TS + 1;
  localparam int IDX_W = 2 * CNT_W;

  logic [ADDR_W-1:0]   base_q;
  logic [CNT_W-1:0]    tiles_y_q, tiles_x_q;
  logic [CNT_W-1:0]    ty_q, tx_q;
  logic [IDX_W-1:0]    tile_idx;
  logic [IDX_W+TS-1:0] tile_off;
  logic                unused_dim_lsbs;

  // Only whole tiles matter; the in-tile part of each dimension is don't-care.
  assign unused_dim_lsbs = ^{h_dim[TS-1:0], w_dim[TS-1:0]};

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      base_q    <= '0;
      tiles_y_q <= '0;
      tiles_x_q <= '0;
      ty_q      <= '0;
      tx_q      <= '0;
    end else if (start) begin
      base_q    <= base_addr;
      tiles_y_q <= CNT_W'(h_dim[DIM_W-1:TS]) + CNT_W'(1);
      tiles_x_q <= CNT_W'(w_dim[DIM_W-1:TS]) + CNT_W'(1);
      ty_q      <= '0;
      tx_q      <= '0;
    end else if (advance) begin
      if (ty_q == tiles_y_q - CNT_W'(1)) begin
        ty_q <= '0;
        tx_q <= tx_q + CNT_W'(1);
      end else begin
        ty_q <= ty_q + CNT_W'(1);
      end
    end
  end

  assign tile_idx  = IDX_W'(tx_q) * IDX_W'(tiles_y_q) + IDX_W'(ty_q);
  assign tile_off  = {tile_idx, {TS{1'b0}}};
  // Silent wrap: truncation to ADDR_W is intended.
  assign addr      = base_q + ADDR_W'(tile_off) + ADDR_W'(row);
  assign last_tile = (ty_q == tiles_y_q - CNT_W'(1)) && (tx_q == tiles_x_q - CNT_W'(1));

endmodule

// File: rtl/weight_load_control_unit.sv
// weight_load_control_unit
//   Producer side of the weight-tile handshake for the systolic array. Fetches
//   each MUL_SIZE-row tile into the shadow weight registers, then swaps it into
//   the active registers when the compute side is free or consumes a tile.
//   Optional macro WLCU_STALL_CNT_EN adds stall_cnt_o (cycles busy with no
//   valid active tile after the first swap, saturating).
// Ports
//   clk_i, rst_i                : clock, asynchronous active-low reset
//   instruction_i               : start request, honoured in IDLE only
//   H_DIM_i, W_DIM_i            : dimensions minus 1, sampled on accept
//   weight_start_addr_i         : base address of tile 0, sampled on accept
//   next_weight_tile_i          : active tile consumed (1-cycle pulse)
//   weight_mem_rd_en_o/addr_o   : weight memory read port (latency 1)
//   load_weight_row_o           : write read data into shadow row
//   weight_row_sel_o            : shadow row index for that write
//   compute_weights_buffered_o  : shadow holds a complete un-swapped tile
//   compute_weights_rdy_o       : active registers hold a valid tile
//   done_o                      : last tile consumed (1-cycle pulse)
//   stall_cnt_o                 : (WLCU_STALL_CNT_EN only) stall cycle count
//
// state     | meaning
// IDLE      | waiting for instruction_i
// FETCH     | reading MUL_SIZE rows of the next tile into the shadow
// WAIT_SWAP | fetch issued; waiting for shadow full and a free active slot
// DRAIN     | last tile active; waiting for it to be consumed
module weight_load_control_unit
  import tpu_package::*;
#(
  parameter int MUL_SIZE = 32,
  parameter int ADDR_W   = 12,
  parameter int DIM_W    = 9,
  localparam int ROW_W   = $clog2(MUL_SIZE)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              instruction_i,
  input  logic [DIM_W-1:0]  H_DIM_i,
  input  logic [DIM_W-1:0]  W_DIM_i,
  input  logic [ADDR_W-1:0] weight_start_addr_i,
  input  logic              next_weight_tile_i,
  output logic              weight_mem_rd_en_o,
  output logic [ADDR_W-1:0] weight_mem_addr_o,
  output logic              load_weight_row_o,
  output logic [ROW_W-1:0]  weight_row_sel_o,
  output logic              compute_weights_buffered_o,
  output logic              compute_weights_rdy_o,
  output logic              done_o
`ifdef WLCU_STALL_CNT_EN
  ,
  output logic [15:0]       stall_cnt_o
`endif
);

  weight_load_state_t state_q, state_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic               active_valid_q, active_valid_d;
  logic               shadow_full_q, shadow_full_d;
  logic               load_q;
  logic [ROW_W-1:0]   load_row_q;
  logic               done_q, done_d;
  logic               accept, rd_en, swap, consume, last_tile;
  logic [ADDR_W-1:0]  row_addr;

  weight_tile_addr_gen #(
    .MUL_SIZE (MUL_SIZE),
    .ADDR_W   (ADDR_W),
    .DIM_W    (DIM_W)
  ) u_addr_gen (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .start     (accept),
    .advance   (swap),
    .h_dim     (H_DIM_i),
    .w_dim     (W_DIM_i),
    .base_addr (weight_start_addr_i),
    .row       (row_q),
    .addr      (row_addr),
    .last_tile (last_tile)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q        <= IDLE;
      row_q          <= '0;
      active_valid_q <= 1'b0;
      shadow_full_q  <= 1'b0;
      load_q         <= 1'b0;
      load_row_q     <= '0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      row_q          <= row_d;
      active_valid_q <= active_valid_d;
      shadow_full_q  <= shadow_full_d;
      load_q         <= rd_en;
      load_row_q     <= row_q;
      done_q         <= done_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    row_d          = '0;
    active_valid_d = active_valid_q;
    shadow_full_d  = shadow_full_q;
    done_d         = 1'b0;

    accept  = (state_q == IDLE) && instruction_i;
    rd_en   = (state_q == FETCH);
    swap    = (state_q == WAIT_SWAP) && shadow_full_q &&
              (!active_valid_q || next_weight_tile_i);
    // A consume pulse with nothing active is dropped.
    consume = next_weight_tile_i && active_valid_q;

    unique case (state_q)
      IDLE: begin
        if (accept) state_d = FETCH;
      end
      FETCH: begin
        row_d = row_q + ROW_W'(1);
        if (row_q == ROW_W'(MUL_SIZE - 1)) state_d = WAIT_SWAP;
      end
      WAIT_SWAP: begin
        if (swap) state_d = last_tile ? DRAIN : FETCH;
      end
      DRAIN: begin
        if (consume) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Shadow full is set one cycle after the last row write lands.
    if (load_q && (load_row_q == ROW_W'(MUL_SIZE - 1))) shadow_full_d = 1'b1;

    // A swap both consumes the old tile and installs the new one.
    if (swap) begin
      active_valid_d = 1'b1;
      shadow_full_d  = 1'b0;
    end else if (consume) begin
      active_valid_d = 1'b0;
    end
  end

  assign weight_mem_rd_en_o         = rd_en;
  assign weight_mem_addr_o          = rd_en ? row_addr : '0;
  assign load_weight_row_o          = load_q;
  assign weight_row_sel_o           = load_row_q;
  assign compute_weights_buffered_o = shadow_full_q;
  assign compute_weights_rdy_o      = active_valid_q;
  assign done_o                     = done_q;

`ifdef WLCU_STALL_CNT_EN
  logic        first_swap_q;
  logic [15:0] stall_cnt_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      first_swap_q <= 1'b0;
      stall_cnt_q  <= '0;
    end else if (accept) begin
      first_swap_q <= 1'b0;
      stall_cnt_q  <= '0;
    end else begin
      if (swap) first_swap_q <= 1'b1;
      if ((state_q != IDLE) && !active_valid_q && first_swap_q &&
          (stall_cnt_q != 16'hFFFF))
        stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_weight_load_control_unit.sv
module tb_weight_load_control_unit;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        instruction_i = 1'b0;
  logic [8:0]  H_DIM_i = '0;
  logic [8:0]  W_DIM_i = '0;
  logic [11:0] weight_start_addr_i = '0;
  logic        next_weight_tile_i = 1'b0;
  logic        weight_mem_rd_en_o;
  logic [11:0] weight_mem_addr_o;
  logic        load_weight_row_o;
  logic [4:0]  weight_row_sel_o;
  logic        compute_weights_buffered_o;
  logic        compute_weights_rdy_o;
  logic        done_o;
`ifdef WLCU_STALL_CNT_EN
  logic [15:0] stall_cnt_o;
`endif

  weight_load_control_unit dut (
    .clk_i                      (clk_i),
    .rst_i                      (rst_i),
    .instruction_i              (instruction_i),
    .H_DIM_i                    (H_DIM_i),
    .W_DIM_i                    (W_DIM_i),
    .weight_start_addr_i        (weight_start_addr_i),
    .next_weight_tile_i         (next_weight_tile_i),
    .weight_mem_rd_en_o         (weight_mem_rd_en_o),
    .weight_mem_addr_o          (weight_mem_addr_o),
    .load_weight_row_o          (load_weight_row_o),
    .weight_row_sel_o           (weight_row_sel_o),
    .compute_weights_buffered_o (compute_weights_buffered_o),
    .compute_weights_rdy_o      (compute_weights_rdy_o),
    .done_o                     (done_o)
`ifdef WLCU_STALL_CNT_EN
    ,
    .stall_cnt_o                (stall_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  localparam logic [3:0] SIG_RDY = 4'd0, SIG_BUF = 4'd1, SIG_DONE = 4'd2, SIG_RDEN = 4'd3,
                         SIG_LOAD = 4'd4, SIG_ADDR = 4'd5, SIG_ROWSEL = 4'd6, SIG_STALL = 4'd7;

  typedef struct packed { logic [11:0] addr; logic [4:0] row; } exp_rd_t;
  typedef struct packed { logic [3:0] sig; logic [31:0] val; } exp_chk_t;

  exp_rd_t  addr_q[$];
  exp_chk_t chk_q[$];
  int       done_q[$];

  int ncyc = 0;
  int checks = 0;
  int errors = 0;
  logic finish_req = 1'b0;

  always @(posedge clk_i) ncyc <= ncyc + 1;

  // ---------------- scoreboard monitor ----------------
  function automatic string sig_name(logic [3:0] s);
    case (s)
      SIG_RDY:    return "rdy";
      SIG_BUF:    return "buffered";
      SIG_DONE:   return "done";
      SIG_RDEN:   return "rd_en";
      SIG_LOAD:   return "load_row";
      SIG_ADDR:   return "addr";
      SIG_ROWSEL: return "row_sel";
      default:    return "stall_cnt";
    endcase
  endfunction

  function automatic logic [31:0] sample(logic [3:0] s);
    case (s)
      SIG_RDY:    return 32'(compute_weights_rdy_o);
      SIG_BUF:    return 32'(compute_weights_buffered_o);
      SIG_DONE:   return 32'(done_o);
      SIG_RDEN:   return 32'(weight_mem_rd_en_o);
      SIG_LOAD:   return 32'(load_weight_row_o);
      SIG_ADDR:   return 32'(weight_mem_addr_o);
      SIG_ROWSEL: return 32'(weight_row_sel_o);
`ifdef WLCU_STALL_CNT_EN
      SIG_STALL:  return 32'(stall_cnt_o);
`endif
      default:    return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", name, ncyc, act, exp);
    end
  endtask

  initial begin : monitor
    exp_chk_t c;
    exp_rd_t  e;
    logic     prev_rd;
    logic [4:0] prev_row;
    logic     exp_load;
    prev_rd  = 1'b0;
    prev_row = '0;
    forever begin
      @(negedge clk_i);
      #1;
      while (chk_q.size() > 0) begin
        c = chk_q.pop_front();
        cmp(sig_name(c.sig), sample(c.sig), c.val);
      end
      exp_load = rst_i && prev_rd;
      cmp("load_row", 32'(load_weight_row_o), 32'(exp_load));
      if (exp_load) cmp("row_sel", 32'(weight_row_sel_o), 32'(prev_row));
      prev_rd = 1'b0;
      if (weight_mem_rd_en_o) begin
        prev_rd = 1'b1;
        if (addr_q.size() == 0) begin
          cmp("unexpected_rd", 32'(weight_mem_addr_o), 32'hFFFF_FFFF);
        end else begin
          e = addr_q.pop_front();
          cmp("rd_addr", 32'(weight_mem_addr_o), 32'(e.addr));
          prev_row = e.row;
        end
      end
      if (done_q.size() > 0 && done_q[0] == ncyc) begin
        void'(done_q.pop_front());
        cmp("done_pulse", 32'(done_o), 32'd1);
      end else if (done_o) begin
        cmp("unexpected_done", 32'(done_o), 32'd0);
      end
      if (finish_req) begin
        cmp("addr_q_left", 32'(addr_q.size()), 32'd0);
        cmp("done_q_left", 32'(done_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, cyc %0d", ncyc);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  task automatic chk(input logic [3:0] s, input logic [31:0] v);
    chk_q.push_back('{sig: s, val: v});
  endtask

  task automatic wait_to(input int c);
    while (ncyc < c) @(negedge clk_i);
  endtask

  task automatic push_tile(input logic [11:0] base, input int k);
    for (int r = 0; r < 32; r++)
      addr_q.push_back('{addr: 12'(int'(base) + k * 32 + r), row: 5'(r)});
  endtask

  task automatic start(input logic [8:0] h, input logic [8:0] w,
                       input logic [11:0] base, output int c0);
    H_DIM_i = h;
    W_DIM_i = w;
    weight_start_addr_i = base;
    instruction_i = 1'b1;
    c0 = ncyc;
    @(negedge clk_i);
    instruction_i = 1'b0;
  endtask

  task automatic pulse_next();
    next_weight_tile_i = 1'b1;
    @(negedge clk_i);
    next_weight_tile_i = 1'b0;
  endtask

  initial begin : stim
    int c0;
    int k;
    @(negedge clk_i);
    // reset state
    chk(SIG_RDY, 0); chk(SIG_BUF, 0); chk(SIG_DONE, 0); chk(SIG_RDEN, 0);
    chk(SIG_ADDR, 0); chk(SIG_ROWSEL, 0);
    @(negedge clk_i);
    rst_i = 1'b1;
    repeat (2) @(negedge clk_i);

    // Test 1: single tile
    push_tile(12'h100, 0);
    start(9'd31, 9'd31, 12'h100, c0);
    wait_to(c0 + 33); chk(SIG_BUF, 0);
    wait_to(c0 + 34); chk(SIG_BUF, 1); chk(SIG_RDY, 0); chk(SIG_RDEN, 0);
    wait_to(c0 + 35); chk(SIG_RDY, 1); chk(SIG_BUF, 0);
    wait_to(c0 + 37);
    instruction_i = 1'b1;                       // ignored in DRAIN
    @(negedge clk_i); instruction_i = 1'b0;
    wait_to(c0 + 40);
    done_q.push_back(c0 + 41);
    pulse_next();
    chk(SIG_RDY, 0);
    wait_to(c0 + 42); chk(SIG_DONE, 0);
    repeat (3) @(negedge clk_i);

    // Test 2 + 6: two tiles, prefetch, swap with rdy held
    push_tile(12'h200, 0); push_tile(12'h200, 1);
    start(9'd63, 9'd31, 12'h200, c0);
    wait_to(c0 + 34); chk(SIG_RDEN, 0);
    wait_to(c0 + 35); chk(SIG_RDEN, 1); chk(SIG_RDY, 1);
    wait_to(c0 + 67); chk(SIG_BUF, 0);
    wait_to(c0 + 68); chk(SIG_BUF, 1); chk(SIG_RDY, 1);
    wait_to(c0 + 70);
    instruction_i = 1'b1;                       // ignored in WAIT_SWAP
    @(negedge clk_i); instruction_i = 1'b0;
    wait_to(c0 + 72); chk(SIG_BUF, 1); chk(SIG_RDY, 1); chk(SIG_RDEN, 0);
    wait_to(c0 + 75); pulse_next();
    chk(SIG_RDY, 1); chk(SIG_BUF, 0);
    wait_to(c0 + 80);
    done_q.push_back(c0 + 81);
    pulse_next();
    chk(SIG_RDY, 0);
    wait_to(c0 + 83); pulse_next();             // rdy = 0: ignored
    chk(SIG_RDY, 0); chk(SIG_BUF, 0); chk(SIG_DONE, 0); chk(SIG_RDEN, 0);
    repeat (3) @(negedge clk_i);

    // Test 3: consume mid-fetch, stall gap
    push_tile(12'h040, 0); push_tile(12'h040, 1);
    start(9'd63, 9'd31, 12'h040, c0);
    wait_to(c0 + 45); pulse_next();
    chk(SIG_RDY, 0);
    wait_to(c0 + 68); chk(SIG_RDY, 0); chk(SIG_BUF, 1);
    wait_to(c0 + 69); chk(SIG_RDY, 1); chk(SIG_BUF, 0);
`ifdef WLCU_STALL_CNT_EN
    chk(SIG_STALL, 23);
`endif
    wait_to(c0 + 72);
    done_q.push_back(c0 + 73);
    pulse_next();
    chk(SIG_RDY, 0);
    repeat (3) @(negedge clk_i);

    // Test 4: 256 tiles with address wrap
    for (int t = 0; t < 256; t++) push_tile(12'hFF0, t);
    start(9'd511, 9'd511, 12'hFF0, c0);
    for (int i = 0; i < 256; i++) begin
      k = 0;
      while (!(compute_weights_rdy_o && (compute_weights_buffered_o || i == 255)) && k < 100) begin
        @(negedge clk_i);
        k++;
      end
      if (k >= 100) begin
        chk(SIG_RDY, 1);
        if (i < 255) chk(SIG_BUF, 1);
      end
      if (i == 255) done_q.push_back(ncyc + 1);
      pulse_next();
    end
    chk(SIG_RDY, 0);
    repeat (3) @(negedge clk_i);

    // Test 5: reset during FETCH row 10, then clean restart
    for (int r = 0; r < 10; r++) addr_q.push_back('{addr: 12'(12'h300 + r), row: 5'(r)});
    start(9'd31, 9'd31, 12'h300, c0);
    wait_to(c0 + 11);
    rst_i = 1'b0;
    chk(SIG_RDEN, 0); chk(SIG_ADDR, 0); chk(SIG_LOAD, 0); chk(SIG_ROWSEL, 0);
    chk(SIG_RDY, 0); chk(SIG_BUF, 0); chk(SIG_DONE, 0);
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    push_tile(12'h300, 0);
    start(9'd31, 9'd31, 12'h300, c0);
    wait_to(c0 + 1); chk(SIG_RDEN, 1); chk(SIG_ADDR, 32'h300);
    wait_to(c0 + 35); chk(SIG_RDY, 1);
    wait_to(c0 + 40);
    done_q.push_back(c0 + 41);
    pulse_next();
    repeat (3) @(negedge clk_i);

    finish_req = 1'b1;
  end

endmodule
